// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into IF/ID with redirect, stall and flush.
module fetch_stage #(
    parameter int PCSize               = 32,
    parameter int InstructionSize      = 32,
    parameter int AmountOfInstructions = 128,
    parameter logic [PCSize-1:0]          ResetPC = '0,
    parameter logic [InstructionSize-1:0] NopWord = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       branch_taken,
    input  logic [PCSize-1:0]          branch_target,
    output logic [PCSize-1:0]          pc_out,
    input  logic [InstructionSize-1:0] instr_in,
    output logic [InstructionSize-1:0] if_id_instr,
    output logic [PCSize-1:0]          if_id_pc_plus4,
    output logic                       if_id_valid,
    output logic                       fault,
    output logic [15:0]                fetch_count
);

    localparam logic [PCSize-1:0] MemBytes = PCSize'(AmountOfInstructions);
    localparam logic [PCSize-1:0] LastPC   = PCSize'(AmountOfInstructions - 4);

    logic [PCSize-1:0] pc;
    logic [PCSize-1:0] pc_plus4;
    logic [PCSize-1:0] seq;
    logic [PCSize-1:0] tgt_align;
    logic [PCSize-1:0] tgt_pc;
    logic [PCSize-1:0] pc_nxt;
    logic              bad;

    assign pc_out    = pc;
    assign pc_plus4  = pc + PCSize'(4);
    assign seq       = (pc_plus4 >= MemBytes) ? '0 : pc_plus4;
    assign tgt_align = {branch_target[PCSize-1:2], 2'b00};
    assign bad       = (branch_target[1:0] != 2'b00) ||
                       (branch_target > LastPC);
    // Good targets are already aligned and in range, so the fold is a no-op.
    assign tgt_pc    = tgt_align % MemBytes;

    always_comb begin
        pc_nxt = pc;
        priority case (1'b1)
            branch_taken: pc_nxt = tgt_pc;
            !stall:       pc_nxt = seq;
            default:      pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= ResetPC;
            if_id_instr    <= NopWord;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fault          <= 1'b0;
            fetch_count    <= '0;
        end else begin
            pc <= pc_nxt;
            if (branch_taken && bad)
                fault <= 1'b1;
            priority case (1'b1)
                flush: begin
                    if_id_instr <= NopWord;
                    if_id_valid <= 1'b0;
                end
                stall: begin
                    if_id_instr <= if_id_instr;
                    if_id_valid <= if_id_valid;
                end
                default: begin
                    if_id_instr    <= instr_in;
                    if_id_pc_plus4 <= pc_plus4;
                    if_id_valid    <= 1'b1;
                    fetch_count    <= fetch_count + 16'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table plus reset and
// sticky-fault sequences against a small combinational memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fault;
    logic [15:0] fetch_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'd0) ? 32'hA1B2C3D4 : {16'hBEEF, a[15:0]};
    endfunction

    assign instr_in = mem(pc_out);

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        fault;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic f, input logic b,
                         input logic [31:0] t);
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " pc"},    pc_out,                 v.pc);
        chk({tag, " valid"}, 32'(if_id_valid),       32'(v.valid));
        chk({tag, " instr"}, if_id_instr,            v.instr);
        chk({tag, " pp4"},   if_id_pc_plus4,         v.pp4);
        chk({tag, " fault"}, 32'(fault),             32'(v.fault));
        chk({tag, " cnt"},   32'(fetch_count),       32'(v.cnt));
    endtask

    initial begin
        // stall flush br tgt | pc valid instr pp4 fault cnt
        vecs[0]  = '{0,0,0,  0,   4, 1, 32'hA1B2C3D4,   4, 0,  1};
        vecs[1]  = '{0,0,0,  0,   8, 1, 32'hBEEF0004,   8, 0,  2};
        vecs[2]  = '{0,0,0,  0,  12, 1, 32'hBEEF0008,  12, 0,  3};
        vecs[3]  = '{0,0,0,  0,  16, 1, 32'hBEEF000C,  16, 0,  4};
        vecs[4]  = '{1,0,0,  0,  16, 1, 32'hBEEF000C,  16, 0,  4};
        vecs[5]  = '{1,0,0,  0,  16, 1, 32'hBEEF000C,  16, 0,  4};
        vecs[6]  = '{0,0,0,  0,  20, 1, 32'hBEEF0010,  20, 0,  5};
        vecs[7]  = '{1,1,1, 40,  40, 0, 32'h00000000,  20, 0,  5};
        vecs[8]  = '{0,0,0,  0,  44, 1, 32'hBEEF0028,  44, 0,  6};
        vecs[9]  = '{0,1,0,  0,  48, 0, 32'h00000000,  44, 0,  6};
        vecs[10] = '{1,1,0,  0,  48, 0, 32'h00000000,  44, 0,  6};
        vecs[11] = '{0,0,1,120, 120, 1, 32'hBEEF0030,  52, 0,  7};
        vecs[12] = '{0,0,0,  0, 124, 1, 32'hBEEF0078, 124, 0,  8};
        vecs[13] = '{0,0,0,  0,   0, 1, 32'hBEEF007C, 128, 0,  9};
        vecs[14] = '{0,0,1,124, 124, 1, 32'hA1B2C3D4,   4, 0, 10};
        vecs[15] = '{0,0,1,128,   0, 1, 32'hBEEF007C, 128, 1, 11};
        vecs[16] = '{1,0,1,200,  72, 1, 32'hBEEF007C, 128, 1, 11};
        vecs[17] = '{0,0,0,  0,  76, 1, 32'hBEEF0048,  76, 1, 12};

        rst = 1'b1;
        stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_all("reset", '{0,0,0,0, 0,0,32'h0,0,0,0});

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
            chk_all($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle with fault set and IF/ID full.
        #2 rst = 1'b1;
        #1;
        chk("async pc",    pc_out,              32'd0);
        chk("async valid", 32'(if_id_valid),    32'd0);
        chk("async fault", 32'(fault),          32'd0);
        chk("async cnt",   32'(fetch_count),    32'd0);
        chk("async instr", if_id_instr,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        drive(0, 0, 0, 0);
        chk("seq pc", pc_out, 32'd4);
        drive(0, 0, 1, 42);
        chk("bad42 pc",    pc_out,           32'd40);
        chk("bad42 fault", 32'(fault),       32'd1);
        chk("bad42 instr", if_id_instr,      32'hBEEF0004);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 8);
        chk("good8 pc",    pc_out,           32'd8);
        chk("sticky fault", 32'(fault),      32'd1);

        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            chk($sformatf("stall%0d pc", k),  pc_out,            32'd8);
            chk($sformatf("stall%0d cnt", k), 32'(fetch_count),  32'd4);
            chk($sformatf("stall%0d pp4", k), if_id_pc_plus4,    32'd48);
        end
        drive(0, 0, 0, 0);
        chk("resume pc",    pc_out,           32'd12);
        chk("resume instr", if_id_instr,      32'hBEEF0008);
        chk("resume fault", 32'(fault),       32'd1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("clr fault", 32'(fault), 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
